// File: rtl/pb_input_fifo.sv
// Read-side port block for the PicoBlaze: a byte FIFO filled by external logic
// and drained through INPUT instructions, plus status and fill-count ports.
module pb_input_fifo #(
    parameter int         DEPTH_LOG2  = 4,
    parameter logic [7:0] DATA_ADDR   = 8'h00,
    parameter logic [7:0] STATUS_ADDR = 8'h01,
    parameter logic [7:0] COUNT_ADDR  = 8'h02
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            port_id,
    input  logic                  read_strobe,
    output logic [7:0]            in_port,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [7:0]            in_port_q, in_port_d;

    logic pop_req, pop_ok, push_ok, ovf_set, udf_set, flag_clr;

    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_CNT);
    assign in_port = in_port_q;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign pop_req  = read_strobe && (port_id == DATA_ADDR);
    assign pop_ok   = pop_req && !empty;
    assign udf_set  = pop_req && empty;
    assign push_ok  = wr_en && (!full || pop_ok);
    assign ovf_set  = wr_en && full && !pop_ok;
    assign flag_clr = read_strobe && (port_id == STATUS_ADDR);

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        in_port_d = 8'h00;

        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Set beats clear so an event in the clearing cycle is never lost.
        ovf_d = (ovf_q && !flag_clr) || ovf_set;
        udf_d = (udf_q && !flag_clr) || udf_set;

        if (port_id == DATA_ADDR) begin
            in_port_d = empty ? 8'h00 : mem_q[rd_ptr_q];
        end else if (port_id == STATUS_ADDR) begin
            in_port_d = {4'b0000, udf_q, ovf_q, full, empty};
        end else if (port_id == COUNT_ADDR) begin
            in_port_d = 8'(count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            in_port_q <= 8'h00;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            in_port_q <= in_port_d;
        end
    end

    // Storage needs no reset; stale entries are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_pb_input_fifo.sv
// Scoreboard bench for pb_input_fifo: INPUT sequences queue the byte the
// processor should capture; a monitor compares it on every read_strobe cycle.
module tb_pb_input_fifo;

    localparam logic [7:0] DATA_ADDR   = 8'h00;
    localparam logic [7:0] STATUS_ADDR = 8'h01;
    localparam logic [7:0] COUNT_ADDR  = 8'h02;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] port_id;
    logic       read_strobe;
    logic [7:0] in_port;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic [4:0] count;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] expQ[$];

    pb_input_fifo #(
        .DEPTH_LOG2 (4),
        .DATA_ADDR  (DATA_ADDR),
        .STATUS_ADDR(STATUS_ADDR),
        .COUNT_ADDR (COUNT_ADDR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .port_id    (port_id),
        .read_strobe(read_strobe),
        .in_port    (in_port),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    always #5 clk = ~clk;

    // The processor captures in_port in the strobe cycle; check it mid-cycle.
    always @(negedge clk) begin
        if (read_strobe && !reset) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL capture: got %h with no expected byte queued", in_port);
            end else begin
                logic [7:0] exp;
                exp = expQ.pop_front();
                if (in_port !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL capture port %h: got %h, expected %h", port_id, in_port, exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic pushByte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] port, input logic [7:0] exp,
                                 input logic doPush, input logic [7:0] pushData);
        port_id     = port;
        read_strobe = 1'b0;
        tick();
        read_strobe = 1'b1;
        wr_en       = doPush;
        wr_data     = pushData;
        expQ.push_back(exp);
        tick();
        read_strobe = 1'b0;
        wr_en       = 1'b0;
    endtask

    task automatic inputRead(input logic [7:0] port, input logic [7:0] exp);
        applyStimulus(port, exp, 1'b0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        port_id     = STATUS_ADDR;
        read_strobe = 1'b0;
        wr_en       = 1'b0;
        wr_data     = 8'h00;

        // Reset, then status idle read
        tick();
        tick();
        checkOutput("reset in_port", in_port, 8'h00);
        reset = 1'b0;
        tick();
        checkOutput("idle status", in_port, 8'h01);
        checkOutput("idle count", 8'(count), 8'd0);
        checkOutput("idle empty", {7'b0, empty}, 8'h01);
        checkOutput("idle full", {7'b0, full}, 8'h00);

        // Two pushes, two pops
        pushByte(8'hA5);
        pushByte(8'h3C);
        checkOutput("count after 2 pushes", 8'(count), 8'd2);
        inputRead(DATA_ADDR, 8'hA5);
        checkOutput("count after pop 1", 8'(count), 8'd1);
        inputRead(DATA_ADDR, 8'h3C);
        checkOutput("count after pop 2", 8'(count), 8'd0);
        checkOutput("empty after drain", {7'b0, empty}, 8'h01);

        // Overfill: 17 pushes, last dropped
        for (int i = 0; i < 17; i++) begin
            pushByte(8'(i));
            if (i == 15) begin
                checkOutput("full at 16", {7'b0, full}, 8'h01);
            end
        end
        checkOutput("count when full", 8'(count), 8'd16);
        inputRead(STATUS_ADDR, 8'h06);
        // Overflow set in the clearing cycle survives the clear
        applyStimulus(STATUS_ADDR, 8'h02, 1'b1, 8'h99);
        inputRead(STATUS_ADDR, 8'h06);
        inputRead(STATUS_ADDR, 8'h02);
        inputRead(COUNT_ADDR, 8'h10);

        // Full FIFO: push 77 together with a pop
        applyStimulus(DATA_ADDR, 8'h00, 1'b1, 8'h77);
        checkOutput("count full push+pop", 8'(count), 8'd16);
        inputRead(STATUS_ADDR, 8'h02);
        for (int i = 1; i < 16; i++) begin
            inputRead(DATA_ADDR, 8'(i));
        end
        inputRead(DATA_ADDR, 8'h77);
        checkOutput("count after full drain", 8'(count), 8'd0);

        // Underflow on empty pop
        inputRead(DATA_ADDR, 8'h00);
        inputRead(STATUS_ADDR, 8'h09);
        inputRead(STATUS_ADDR, 8'h01);
        applyStimulus(DATA_ADDR, 8'h00, 1'b1, 8'h5A);
        checkOutput("count empty push+pop", 8'(count), 8'd1);
        inputRead(STATUS_ADDR, 8'h08);
        inputRead(COUNT_ADDR, 8'h01);
        inputRead(8'h33, 8'h00);
        checkOutput("count after unmapped read", 8'(count), 8'd1);
        inputRead(DATA_ADDR, 8'h5A);
        checkOutput("empty after 5A", {7'b0, empty}, 8'h01);

        // Reset mid-stream with wr_en held
        for (int i = 0; i < 5; i++) begin
            pushByte(8'h11 + 8'(i));
        end
        port_id = DATA_ADDR;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        wr_en   = 1'b0;
        checkOutput("count after reset", 8'(count), 8'd0);
        checkOutput("empty after reset", {7'b0, empty}, 8'h01);
        checkOutput("in_port after reset", in_port, 8'h00);
        pushByte(8'hC7);
        pushByte(8'hC8);
        inputRead(DATA_ADDR, 8'hC7);
        inputRead(DATA_ADDR, 8'hC8);
        checkOutput("count end", 8'(count), 8'd0);

        tick();
        checkOutput("scoreboard drained", 8'(expQ.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pb_input_fifo.md
Name: pb_input_fifo

Overview:
- Input-side peripheral for the KCPSM3 (PicoBlaze) processor in `main`. It is the read end of the processor port interface: `main` already writes `out_port`, and this block supplies `in_port`.
- External logic pushes bytes into an internal FIFO. The processor pops them with INPUT instructions on a data port and polls status/count ports.
- It sits between a byte source (UART RX, test stimulus) and the processor's `in_port`/`port_id`/`read_strobe`.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 entries).
- DATA_ADDR, 8'h00, port_id that reads the FIFO head; a read here pops one entry.
- STATUS_ADDR, 8'h01, port_id of the status byte.
- COUNT_ADDR, 8'h02, port_id of the fill count.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- port_id  input  8  processor port address.
- read_strobe  input  1  processor INPUT strobe; high for one cycle, in the second cycle port_id is valid.
- in_port  output  8  registered read data to the processor.
- wr_data  input  8  byte to push.
- wr_en  input  1  push request, one byte per cycle while high.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  DEPTH_LOG2+1  current fill level, 0..DEPTH.

Behaviour:
- Storage: DEPTH x 8 array, with read/write pointers of width DEPTH_LOG2 that wrap modulo DEPTH. count is a separate register.
- Reset (synchronous, reset high at a rising edge):
  - pointers = 0, count = 0, in_port = 8'h00.
  - sticky overflow/underflow flags = 0.
  - empty = 1, full = 0.
  - Array contents are don't-care.
  - Reset overrides wr_en/read_strobe in the same cycle and may arrive mid-stream; all queued data is discarded.
- in_port mux, registered, 1-cycle latency: every cycle in_port <= selected value for the current port_id.
  - DATA_ADDR: mem[rd_ptr] if not empty, else 8'h00.
  - STATUS_ADDR: {4'b0, underflow, overflow, full, empty}.
  - COUNT_ADDR: count zero-extended to 8 bits.
  - Any other port_id: 8'h00.
  - Because port_id is stable for 2 cycles, in_port is valid in the read_strobe cycle, when the processor captures it.
- Pop: read_strobe high and port_id == DATA_ADDR.
  - If not empty: rd_ptr increments and count decrements at the end of that cycle.
  - If empty: no pointer change and underflow is set.
- Push: wr_en high.
  - If not full, or a valid pop happens in the same cycle: mem[wr_ptr] <= wr_data, wr_ptr increments, count increments.
  - If full with no pop in the same cycle: the byte is dropped and overflow is set.
- Simultaneous push and pop:
  - Not empty: both occur and count is unchanged. When full this also holds: the pop frees the slot and the push is accepted.
  - Empty: the pop is an underflow (sets underflow), the push is accepted, and count becomes 1.
- Status clear: read_strobe with port_id == STATUS_ADDR clears overflow and underflow at the end of that cycle.
  - The value the processor captures still shows the pre-clear flags.
  - If a set event occurs in the same cycle as a clear, the set wins.
- full and empty are decoded combinationally from the count register. They reflect the post-edge state, with no extra latency.
- read_strobe with any unmapped port_id has no side effects.

Test Plan:
1. Reset then idle, port_id=STATUS_ADDR → in_port=8'h01 after 1 cycle; count=0, empty=1, full=0.
2. Push 8'hA5, 8'h3C. Then do two INPUT sequences on DATA_ADDR (port_id held 2 cycles, read_strobe in cycle 2).
   → Captured bytes are A5 then 3C; count goes 2→1→0; empty=1 at the end.
3. Push 17 bytes 8'h00..8'h10 with no reads.
   → full=1 after 16 bytes, count=16, byte 8'h10 dropped; status read = 8'h06.
   → A second status read = 8'h02 (overflow cleared).
   → Draining returns 00..0F in order, confirming pointer wrap.
4. With the FIFO full, assert wr_en=8'h77 and pop in the same cycle.
   → Popped byte is the head; count stays 16; overflow stays 0; 8'h77 is read last.
5. With the FIFO empty, pop on DATA_ADDR → captured in_port=8'h00 and underflow=1 (status 8'h09).
   → A simultaneous push of 8'h5A leaves count=1, and the next pop returns 5A.
6. Push 5 bytes, then assert reset for one cycle mid-stream with wr_en still high.
   → count=0, empty=1, in_port=0; the first push after reset is read back first.
